// File: rtl/pe_bitserial_ctrl_pkg.sv
// Shared constants for the bit-serial PE controller: datapath widths, precision codes,
// FSM state type and the precision-to-slice-count helper.
package pe_bitserial_ctrl_pkg;

  localparam int unsigned BITS_ACT           = 8;
  localparam int unsigned BITS_WEIGHT        = 8;
  localparam int unsigned BITS_SIP_DOT_ADDER = BITS_ACT + BITS_WEIGHT;

  localparam logic [1:0] PREC_2B     = 2'd0;
  localparam logic [1:0] PREC_4B     = 2'd1;
  localparam logic [1:0] PREC_8B     = 2'd2;
  localparam logic [1:0] PREC_8B_ALT = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  // Index of the last 2-bit slice for a precision code (slice count minus one).
  function automatic logic [1:0] slice_last(input logic [1:0] prec);
    logic [1:0] last;
    case (prec)
      PREC_2B:     last = 2'd0;
      PREC_4B:     last = 2'd1;
      PREC_8B:     last = 2'd3;
      PREC_8B_ALT: last = 2'd3;
      default:     last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/pe_bitserial_ctrl_psum_acc.sv
// Shift-accumulate datapath: sign-extends each valid PE partial sum, shifts it by the
// slice weight and adds it into a wrapping accumulator.
module pe_psum_acc #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned PSUM_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              valid,
  input  logic [3:0]        shift,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] psum_ext;

  assign psum_ext = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (valid) begin
      acc <= acc + (psum_ext << shift);
    end
  end

endmodule

// File: rtl/pe_bitserial_ctrl.sv
// Sequencer for a 2-bit-slice bit-serial PE: walks weight/activation slices, drives the PE
// select and sign controls, and accumulates the shifted partial sums into one dot product.
// Optional signed-activation support is enabled with `define PE_CTRL_SIGNED_ACT_EN.
module pe_bitserial_ctrl
  import pe_bitserial_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [1:0]                    cfg_act_prec,
  input  logic [1:0]                    cfg_wgt_prec,
  input  logic                          cfg_signed_w,
`ifdef PE_CTRL_SIGNED_ACT_EN
  input  logic                          cfg_signed_a,
`endif
  output logic [1:0]                    o_act_sel,
  output logic [1:0]                    o_wgt_sel,
  output logic [1:0]                    o_BF,
  output logic                          o_SignI,
  input  logic [BITS_SIP_DOT_ADDER-1:0] i_psum,
  output logic [ACC_W-1:0]              o_result,
  output logic                          o_result_valid,
  input  logic                          i_result_ready,
  output logic                          o_busy
);

  state_e           state_q;
  logic [1:0]       na_last_q, nw_last_q, na_last_nxt, nw_last_nxt;
  logic             signed_w_q, signed_w_nxt;
  logic             accept, issue_last, issue_nxt;
  logic [1:0]       act_nxt, wgt_nxt;
  logic             psum_vld_q;
  logic [1:0]       act_d1_q, wgt_d1_q;
  logic [3:0]       shift;
  logic [ACC_W-1:0] acc;

  // Next-cycle slice selects; outputs are registered from these so they line up with state.
  always_comb begin
    accept       = (state_q == StIdle) && start_valid;
    issue_last   = (state_q == StIssue) && (o_act_sel == na_last_q) && (o_wgt_sel == nw_last_q);
    issue_nxt    = accept || ((state_q == StIssue) && !issue_last);
    na_last_nxt  = accept ? slice_last(cfg_act_prec) : na_last_q;
    nw_last_nxt  = accept ? slice_last(cfg_wgt_prec) : nw_last_q;
    signed_w_nxt = accept ? cfg_signed_w : signed_w_q;
    act_nxt      = 2'd0;
    wgt_nxt      = 2'd0;
    if ((state_q == StIssue) && !issue_last) begin
      if (o_act_sel == na_last_q) begin
        act_nxt = 2'd0;
        wgt_nxt = o_wgt_sel + 2'd1;
      end else begin
        act_nxt = o_act_sel + 2'd1;
        wgt_nxt = o_wgt_sel;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= StIdle;
      start_ready    <= 1'b1;
      o_busy         <= 1'b0;
      na_last_q      <= 2'd0;
      nw_last_q      <= 2'd0;
      signed_w_q     <= 1'b0;
      o_act_sel      <= 2'd0;
      o_wgt_sel      <= 2'd0;
      o_BF           <= 2'd0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
    end else begin
      na_last_q  <= na_last_nxt;
      nw_last_q  <= nw_last_nxt;
      signed_w_q <= signed_w_nxt;
      o_act_sel  <= act_nxt;
      o_wgt_sel  <= wgt_nxt;
      o_BF       <= {1'b0, issue_nxt && signed_w_nxt && (wgt_nxt == nw_last_nxt)};
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StIssue;
            start_ready <= 1'b0;
            o_busy      <= 1'b1;
          end
        end
        StIssue: begin
          if (issue_last) state_q <= StDrain;
        end
        StDrain: state_q <= StDone;
        StDone: begin
          // First DONE cycle snapshots the accumulator, which saw the last psum in DRAIN.
          if (!o_result_valid) begin
            o_result_valid <= 1'b1;
            o_result       <= acc;
          end else if (i_result_ready) begin
            o_result_valid <= 1'b0;
            state_q        <= StIdle;
            start_ready    <= 1'b1;
            o_busy         <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PE_CTRL_SIGNED_ACT_EN
  logic signed_a_q, signed_a_nxt, sign_i_q;

  assign signed_a_nxt = accept ? cfg_signed_a : signed_a_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      signed_a_q <= 1'b0;
      sign_i_q   <= 1'b0;
    end else begin
      signed_a_q <= signed_a_nxt;
      sign_i_q   <= issue_nxt && signed_a_nxt && (act_nxt == na_last_nxt);
    end
  end

  assign o_SignI = sign_i_q;
`else
  assign o_SignI = 1'b0;
`endif

  // The PE registers its output, so each psum pairs with the selects of the previous cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      psum_vld_q <= 1'b0;
      act_d1_q   <= 2'd0;
      wgt_d1_q   <= 2'd0;
    end else begin
      psum_vld_q <= (state_q == StIssue);
      act_d1_q   <= o_act_sel;
      wgt_d1_q   <= o_wgt_sel;
    end
  end

  assign shift = {({1'b0, act_d1_q} + {1'b0, wgt_d1_q}), 1'b0};

  pe_psum_acc #(
    .ACC_W  (ACC_W),
    .PSUM_W (BITS_SIP_DOT_ADDER)
  ) u_psum_acc (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (accept),
    .valid (psum_vld_q),
    .shift (shift),
    .psum  (i_psum),
    .acc   (acc)
  );

endmodule

// File: tb/tb_pe_bitserial_ctrl.sv
// Bench for pe_bitserial_ctrl: table vectors, reset-abort sequence and random runs checked
// against a dot-product reference model; the bench itself plays the registered PE.
module tb_pe_bitserial_ctrl;
  import pe_bitserial_ctrl_pkg::*;

  localparam int unsigned ACC_W = 32;

  logic                          CLK = 1'b0;
  logic                          RESET;
  logic                          start_valid;
  logic                          start_ready;
  logic [1:0]                    cfg_act_prec;
  logic [1:0]                    cfg_wgt_prec;
  logic                          cfg_signed_w;
`ifdef PE_CTRL_SIGNED_ACT_EN
  logic                          cfg_signed_a;
`endif
  logic [1:0]                    o_act_sel;
  logic [1:0]                    o_wgt_sel;
  logic [1:0]                    o_BF;
  logic                          o_SignI;
  logic [BITS_SIP_DOT_ADDER-1:0] i_psum;
  logic [ACC_W-1:0]              o_result;
  logic                          o_result_valid;
  logic                          i_result_ready;
  logic                          o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int psum_seq[16];

  typedef struct {
    logic [1:0] ap;
    logic [1:0] wp;
    logic       sw;
    logic       sa;
    int         psum;
    longint     exp;
    int         hold;
  } vec_t;

  vec_t tbl[7];

  always #5 CLK = ~CLK;

  pe_bitserial_ctrl #(
    .ACC_W (ACC_W)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .cfg_act_prec   (cfg_act_prec),
    .cfg_wgt_prec   (cfg_wgt_prec),
    .cfg_signed_w   (cfg_signed_w),
`ifdef PE_CTRL_SIGNED_ACT_EN
    .cfg_signed_a   (cfg_signed_a),
`endif
    .o_act_sel      (o_act_sel),
    .o_wgt_sel      (o_wgt_sel),
    .o_BF           (o_BF),
    .o_SignI        (o_SignI),
    .i_psum         (i_psum),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_busy         (o_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int slices(input logic [1:0] prec);
    return (prec == 2'd0) ? 1 : (prec == 2'd1) ? 2 : 4;
  endfunction

  // Dot product straight from the definition: psum(w,a) weighted by 4^(a+w).
  function automatic longint ref_dot(input int na, input int nw);
    longint s = 0;
    for (int i = 0; i < na * nw; i++) begin
      int w = i / na;
      int a = i % na;
      s += longint'(psum_seq[i]) * (longint'(1) << (2 * (a + w)));
    end
    return s;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " start_ready"}, 64'(start_ready), 64'd1);
    check({tag, " busy"}, 64'(o_busy), 64'd0);
    check({tag, " valid"}, 64'(o_result_valid), 64'd0);
    check({tag, " sels_bf_signi"}, 64'({o_act_sel, o_wgt_sel, o_BF, o_SignI}), 64'd0);
  endtask

  // Runs one dot product; called with time aligned 1 after a rising edge, DUT in IDLE.
  task automatic run(input logic [1:0] ap, input logic [1:0] wp, input logic sw, input logic sa,
                     input longint exp, input int hold, input string tag);
    int na, nw, n, a, w;
    logic sa_eff;
    logic [ACC_W-1:0] exp_r;
    na = slices(ap);
    nw = slices(wp);
    n  = na * nw;
`ifdef PE_CTRL_SIGNED_ACT_EN
    sa_eff = sa;
    cfg_signed_a = sa;
`else
    sa_eff = 1'b0 & sa;
`endif
    exp_r = exp[ACC_W-1:0];
    check({tag, " start_ready"}, 64'(start_ready), 64'd1);
    cfg_act_prec   = ap;
    cfg_wgt_prec   = wp;
    cfg_signed_w   = sw;
    start_valid    = 1'b1;
    i_result_ready = 1'b0;
    @(posedge CLK);
    for (int k = 0; k <= n + 2; k++) begin
      if (k > 0) @(posedge CLK);
      #1;
      // Mid-run configuration and start requests must be ignored.
      cfg_act_prec = 2'($urandom);
      cfg_wgt_prec = 2'($urandom);
      cfg_signed_w = 1'($urandom);
`ifdef PE_CTRL_SIGNED_ACT_EN
      cfg_signed_a = 1'($urandom);
`endif
      start_valid = 1'($urandom);
      if (k >= 1 && k <= n) i_psum = psum_seq[k-1][BITS_SIP_DOT_ADDER-1:0];
      else i_psum = BITS_SIP_DOT_ADDER'($urandom);
      if (k < n) begin
        w = k / na;
        a = k % na;
        check($sformatf("%s k%0d act_sel", tag, k), 64'(o_act_sel), 64'(a));
        check($sformatf("%s k%0d wgt_sel", tag, k), 64'(o_wgt_sel), 64'(w));
        check($sformatf("%s k%0d BF", tag, k), 64'(o_BF), 64'(sw && (w == nw - 1)));
        check($sformatf("%s k%0d SignI", tag, k), 64'(o_SignI), 64'(sa_eff && (a == na - 1)));
      end else begin
        check($sformatf("%s k%0d ctl_zero", tag, k),
              64'({o_act_sel, o_wgt_sel, o_BF, o_SignI}), 64'd0);
      end
      check($sformatf("%s k%0d busy", tag, k), 64'(o_busy), 64'd1);
      check($sformatf("%s k%0d start_ready", tag, k), 64'(start_ready), 64'd0);
      check($sformatf("%s k%0d valid", tag, k), 64'(o_result_valid), 64'(k == n + 2));
      if (k == n + 2) begin
        check({tag, " result"}, 64'(o_result), 64'(exp_r));
        i_result_ready = (hold == 0);
      end else begin
        i_result_ready = 1'($urandom);
      end
    end
    for (int h = 1; h <= hold; h++) begin
      @(posedge CLK);
      #1;
      start_valid = 1'b1;
      check($sformatf("%s hold%0d valid", tag, h), 64'(o_result_valid), 64'd1);
      check($sformatf("%s hold%0d result", tag, h), 64'(o_result), 64'(exp_r));
      check($sformatf("%s hold%0d start_ready", tag, h), 64'(start_ready), 64'd0);
      i_result_ready = (h == hold);
    end
    @(posedge CLK);
    #1;
    start_valid    = 1'b0;
    i_result_ready = 1'b0;
    check_idle_outputs({tag, " post"});
  endtask

  initial begin
    tbl[0] = '{2'd0, 2'd0, 1'b0, 1'b0,  5,     5, 0};
    tbl[1] = '{2'd1, 2'd1, 1'b0, 1'b0,  1,    25, 0};
    tbl[2] = '{2'd2, 2'd1, 1'b1, 1'b0, -1,  -425, 2};
    tbl[3] = '{2'd2, 2'd2, 1'b0, 1'b0,  1,  7225, 1};
    tbl[4] = '{2'd0, 2'd2, 1'b1, 1'b0,  3,   255, 0};
    tbl[5] = '{2'd3, 2'd0, 1'b0, 1'b1,  2,   170, 5};
    tbl[6] = '{2'd2, 2'd0, 1'b0, 1'b1, -3,  -255, 0};

    RESET          = 1'b1;
    start_valid    = 1'b0;
    cfg_act_prec   = 2'd0;
    cfg_wgt_prec   = 2'd0;
    cfg_signed_w   = 1'b0;
`ifdef PE_CTRL_SIGNED_ACT_EN
    cfg_signed_a   = 1'b0;
`endif
    i_psum         = '0;
    i_result_ready = 1'b0;
    @(posedge CLK);
    #1;
    check_idle_outputs("reset");
    check("reset result", 64'(o_result), 64'd0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check_idle_outputs("after_reset");

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) psum_seq[i] = tbl[v].psum;
      run(tbl[v].ap, tbl[v].wp, tbl[v].sw, tbl[v].sa, tbl[v].exp, tbl[v].hold,
          $sformatf("vec%0d", v));
    end

    // Reset in the middle of an 8b/8b run aborts it without a result.
    for (int i = 0; i < 16; i++) psum_seq[i] = 9;
    cfg_act_prec = 2'd2;
    cfg_wgt_prec = 2'd2;
    cfg_signed_w = 1'b1;
    start_valid  = 1'b1;
    @(posedge CLK);
    #1;
    start_valid = 1'b0;
    @(posedge CLK);
    #1;
    i_psum = 16'd9;
    @(posedge CLK);
    #1;
    check("abort pre act_sel", 64'(o_act_sel), 64'd2);
    RESET = 1'b1;
    #1;
    check_idle_outputs("abort");
    check("abort result", 64'(o_result), 64'd0);
    #2;
    RESET = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge CLK);
      #1;
      check($sformatf("abort c%0d valid", c), 64'(o_result_valid), 64'd0);
    end
    check("abort busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 16; i++) psum_seq[i] = 7;
    run(2'd0, 2'd0, 1'b0, 1'b0, 64'd7, 0, "after_abort");

    // Random configurations and partial sums against the reference model.
    for (int r = 0; r < 20; r++) begin
      logic [1:0] ap, wp;
      logic sw, sa;
      ap = 2'($urandom_range(0, 3));
      wp = 2'($urandom_range(0, 3));
      sw = 1'($urandom);
      sa = 1'($urandom);
      for (int i = 0; i < 16; i++) psum_seq[i] = int'($urandom_range(0, 65535)) - 32768;
      run(ap, wp, sw, sa, ref_dot(slices(ap), slices(wp)), int'($urandom_range(0, 3)),
          $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
